// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_structural.sv
// Gate-level one-bit full adder; the only arithmetic element of the serial adder.
module full_adder_structural (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  logic ab_xor_s;
  logic ab_and_s;
  logic c_and_s;

  xor g_x0 (ab_xor_s, a, b);
  xor g_x1 (sum, ab_xor_s, carry_in);
  and g_a0 (ab_and_s, a, b);
  and g_a1 (c_and_s, ab_xor_s, carry_in);
  or  g_o0 (carry_out, ab_and_s, c_and_s);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder processes a+b+cin LSB first, one bit per clock,
// and publishes a registered sum/cout with a single-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             load_s;
  logic             shift_s;
  logic             finish_s;
  logic             fa_sum_s;
  logic             fa_cout_s;

  full_adder_structural u_fa (
    .a         (a_sh_r[0]),
    .b         (b_sh_r[0]),
    .carry_in  (carry_r),
    .sum       (fa_sum_s),
    .carry_out (fa_cout_s)
  );

  // Next-state decode and datapath control strobes.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        shift_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          next_state_s = DONE;
          finish_s     = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          next_state_s = RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register, registered status flags and the serial datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy    <= (next_state_s == RUN);
      done    <= (next_state_s == DONE);
      if (load_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        carry_r <= cin;
        cnt_r   <= {CW{1'b0}};
      end else if (shift_s) begin
        a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
        res_r   <= {fa_sum_s, res_r[WIDTH-1:1]};
        carry_r <= fa_cout_s;
        // Counter parks at LAST_CNT on the final bit so it never wraps.
        if (!finish_s) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          sum  <= {fa_sum_s, res_r[WIDTH-1:1]};
          cout <= fa_cout_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit instance with directed vectors
// and a 4-bit instance swept over every operand/carry combination.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_checks;
  int n_fail;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("result8", {23'd0, cout8, sum8}, {23'd0, e});
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        logic [4:0] e;
        e = q4.pop_front();
        chk("result4", {27'd0, cout4, sum4}, {27'd0, e});
      end
    end
  end

  // One 8-bit addition; also checks busy span and done latency.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec);
    int edges;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    q8.push_back({ec, es});
    edges = 0; busy_cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) start8 = 1'b0;
      if (busy8) busy_cnt++;
      if (done8) seen = 1;
    end
    if (!seen) chk("timeout8", 32'd0, 32'd1);
    chk("latency8", edges - 1, 32'd8);
    chk("busy_cycles8", busy_cnt, 32'd8);
  endtask

  initial begin
    logic [7:0] va[5], vb[5], vs[5];
    logic       vc[5], vo[5];
    int  e, t1, t2;
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    chk("reset_done", {31'd0, done8}, 32'd0);
    chk("reset_sum_cout", {23'd0, cout8, sum8}, 32'd0);
    rst = 1'b0;

    // Directed vectors: a, b, cin -> sum, cout (hand computed).
    va = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h80};
    vb = '{8'h00, 8'h01, 8'h5A, 8'h0F, 8'h80};
    vc = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    vs = '{8'h00, 8'h00, 8'h00, 8'h4B, 8'h01};
    vo = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    for (int i = 0; i < 5; i++) run8(va[i], vb[i], vc[i], vs[i], vo[i]);

    // Result holds through IDLE.
    repeat (3) @(negedge clk);
    chk("hold_idle", {23'd0, cout8, sum8}, {23'd0, 1'b1, 8'h01});

    // start held high through RUN: new operands ignored, back-to-back from DONE.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    q8.push_back({1'b0, 8'h46});
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; cin8 = 1'b1;
    q8.push_back({1'b0, 8'h78});
    e = 0; t1 = -1; t2 = -1;
    // e counts edges since the drive; accept edge is e=1.
    e = 1;
    for (int i = 0; i < 60 && t2 < 0; i++) begin
      @(posedge clk); #1;
      e++;
      if (done8) begin
        if (t1 < 0) t1 = e; else t2 = e;
      end
    end
    start8 = 1'b0;
    if (t2 < 0) chk("timeout_b2b", 32'd0, 32'd1);
    chk("b2b_first_done", t1, 32'd9);
    chk("b2b_interval", t2 - t1, 32'd9);
    repeat (2) @(negedge clk);

    // Reset three cycles into RUN abandons the addition.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_run_busy", {31'd0, busy8}, 32'd0);
    chk("rst_run_done", {31'd0, done8}, 32'd0);
    chk("rst_run_sum_cout", {23'd0, cout8, sum8}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", {30'd0, done8, busy8}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run8(8'h21, 8'h43, 1'b1, 8'h65, 1'b0);

    // Exhaustive 4-bit sweep against a + b + cin.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          bit seen;
          @(negedge clk);
          start4 = 1'b1; a4 = ia[3:0]; b4 = ib[3:0]; cin4 = ic[0];
          q4.push_back(5'(ia + ib + ic));
          @(negedge clk);
          start4 = 1'b0;
          seen = 0;
          for (int k = 0; k < 12 && !seen; k++) begin
            @(posedge clk); #1;
            if (done4) seen = 1;
          end
          if (!seen) chk("timeout4", 32'd0, 32'd1);
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
